// File: rtl/serial_byte_loader.sv
// Serial-to-parallel word loader: assembles WIDTH accepted bits behind a
// valid/ready handshake and holds the finished word on out_reg until acked.
module serial_byte_loader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ser_in,
    input  logic                       ser_valid,
    output logic                       ser_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           out_reg,
    output logic                       out_valid,
    input  logic                       out_ack,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic [7:0]                 word_count
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, shifted, out_reg_d;
    logic             out_valid_d, ser_ready_d, accept;
    logic [CW-1:0]    bit_count_d, count_inc;
    logic [7:0]       word_count_d;

    // ser_ready is low in HOLD, so a bit can never be consumed while a word is held.
    assign accept    = ser_valid && ser_ready && !flush;
    assign count_inc = bit_count + CW'(1);

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {shift_q[WIDTH-2:0], ser_in};
        end else begin : g_lsb
            assign shifted = {ser_in, shift_q[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        out_reg_d    = out_reg;
        out_valid_d  = out_valid;
        bit_count_d  = bit_count;
        word_count_d = word_count;
        case (state_q)
            IDLE, SHIFT: begin
                if (flush) begin
                    shift_d     = '0;
                    bit_count_d = '0;
                    state_d     = IDLE;
                end else if (accept) begin
                    if (count_inc == FULL) begin
                        out_reg_d    = shifted;
                        out_valid_d  = 1'b1;
                        shift_d      = '0;
                        bit_count_d  = '0;
                        word_count_d = word_count + 8'd1;
                        state_d      = HOLD;
                    end else begin
                        shift_d     = shifted;
                        bit_count_d = count_inc;
                        state_d     = SHIFT;
                    end
                end
            end
            HOLD: begin
                if (out_ack) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ser_ready_d = (state_d != HOLD);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            out_reg    <= '0;
            out_valid  <= 1'b0;
            ser_ready  <= 1'b0;
            bit_count  <= '0;
            word_count <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            out_reg    <= out_reg_d;
            out_valid  <= out_valid_d;
            ser_ready  <= ser_ready_d;
            bit_count  <= bit_count_d;
            word_count <= word_count_d;
        end
    end
endmodule

// File: tb/tb_serial_byte_loader.sv
// Bench for serial_byte_loader: MSB-first and LSB-first instances share one stimulus
// stream and are compared every cycle against a bit-queue model, plus literal checks.
module tb_serial_byte_loader;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic clk = 1'b0, rst_n = 1'b0;
    logic ser_in = 1'b0, ser_valid = 1'b0, flush = 1'b0, out_ack = 1'b0;
    logic ready_m, ready_l, valid_m, valid_l;
    logic [WIDTH-1:0] out_m, out_l;
    logic [CW-1:0] bc_m, bc_l;
    logic [7:0] wc_m, wc_l;

    int errors = 0, checks = 0, first_wait = 0;

    always #5 clk = ~clk;

    serial_byte_loader #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
        .ser_ready(ready_m), .flush(flush), .out_reg(out_m), .out_valid(valid_m),
        .out_ack(out_ack), .bit_count(bc_m), .word_count(wc_m)
    );

    serial_byte_loader #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
        .ser_ready(ready_l), .flush(flush), .out_reg(out_l), .out_valid(valid_l),
        .out_ack(out_ack), .bit_count(bc_l), .word_count(wc_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Model: accepted bits collect in a queue; a full queue becomes a word for both orders.
    logic             m_live = 1'b0, m_ready = 1'b0, m_valid = 1'b0;
    logic [WIDTH-1:0] m_word_m = '0, m_word_l = '0;
    logic [7:0]       m_wc = '0;
    logic             m_bits[$];

    task automatic model_step();
        if (!rst_n) begin
            m_live = 1'b1;
            m_bits.delete();
            m_ready = 1'b0; m_valid = 1'b0;
            m_word_m = '0; m_word_l = '0; m_wc = '0;
        end else if (m_live) begin
            if (m_valid) begin
                if (out_ack) begin
                    m_valid = 1'b0;
                    m_ready = 1'b1;
                end
            end else begin
                if (flush) m_bits.delete();
                else if (ser_valid && m_ready) begin
                    m_bits.push_back(ser_in);
                    if (m_bits.size() == WIDTH) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            m_word_m[WIDTH-1-i] = m_bits[i];
                            m_word_l[i]         = m_bits[i];
                        end
                        m_valid = 1'b1;
                        m_wc    = m_wc + 8'd1;
                        m_bits.delete();
                    end
                end
                m_ready = !m_valid;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check("ser_ready_msb", ready_m, m_ready);
            check("ser_ready_lsb", ready_l, m_ready);
            check("out_valid_msb", valid_m, m_valid);
            check("out_valid_lsb", valid_l, m_valid);
            check("out_reg_msb", out_m, m_word_m);
            check("out_reg_lsb", out_l, m_word_l);
            check("bit_count_msb", bc_m, m_bits.size());
            check("bit_count_lsb", bc_l, m_bits.size());
            check("word_count_msb", wc_m, m_wc);
            check("word_count_lsb", wc_l, m_wc);
        end
    end

    // Inputs change right after a falling edge and hold for one full cycle.
    task automatic drive(input logic v, input logic b, input logic f, input logic a);
        ser_valid = v; ser_in = b; flush = f; out_ack = a;
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic a, output int waited);
        waited = 0;
        while (!ready_m && waited < 20) begin
            drive(1'b0, 1'b0, 1'b0, a);
            waited++;
        end
        check("ready_wait_bound", 32'(waited < 20), 32'd1);
        drive(1'b1, b, 1'b0, a);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] value, input logic a);
        int w;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(value[i], a, w);
            if (i == WIDTH - 1) first_wait = w;
        end
    endtask

    initial begin
        int w;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_out_reg", out_m, 32'h0);
        check("rst_out_valid", valid_m, 32'd0);
        check("rst_ser_ready", ready_m, 32'd0);
        check("rst_word_count", wc_m, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("ready_after_release", ready_m, 32'd1);

        // Stream 1,0,1,1,0,0,1,0 without ack.
        send_word(8'hB2, 1'b0);
        check("b2_valid", valid_m, 32'd1);
        check("b2_out_msb", out_m, 32'hB2);
        check("b2_out_lsb", out_l, 32'h4D);
        check("b2_word_count", wc_m, 32'd1);
        check("b2_ready", ready_m, 32'd0);
        for (int i = 0; i < 4; i++) drive(i[0], ~i[1], 1'b0, 1'b0);
        check("hold_out_reg", out_m, 32'hB2);
        check("hold_bit_count", bc_m, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        check("hold_flush_valid", valid_m, 32'd1);
        check("hold_flush_out", out_m, 32'hB2);

        // Reset while holding a word.
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("hold_rst_out", out_m, 32'h0);
        check("hold_rst_valid", valid_m, 32'd0);
        check("hold_rst_wc", wc_m, 32'd0);
        check("hold_rst_ready", ready_m, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_rst_release_ready", ready_m, 32'd1);

        // Back-to-back with ack held high.
        send_word(8'hFF, 1'b1);
        check("b2b_ff_valid", valid_m, 32'd1);
        check("b2b_ff_out", out_m, 32'hFF);
        check("b2b_ff_ready", ready_m, 32'd0);
        send_word(8'h01, 1'b1);
        check("b2b_gap_cycles", first_wait, 32'd1);
        check("b2b_01_out", out_m, 32'h01);
        check("b2b_word_count", wc_m, 32'd2);

        // Flush after five ones, then a flush colliding with a valid bit.
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, w);
        check("flush_pre_count", bc_m, 32'd5);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        check("flush_post_count", bc_m, 32'd0);
        send_word(8'h00, 1'b0);
        check("flush_word_out", out_m, 32'h00);
        check("flush_word_valid", valid_m, 32'd1);
        check("flush_word_count", wc_m, 32'd3);

        // Wrap of word_count, with acks while nothing is valid.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, w);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_ack_count", bc_m, 32'd3);
        check("idle_ack_valid", valid_m, 32'd0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1, w);
        check("wrap_first_out", out_m, 32'hE0);
        check("wrap_first_wc", wc_m, 32'd1);
        for (int k = 2; k <= 255; k++) send_word(8'(k * 37), 1'b1);
        check("wrap_wc_255", wc_m, 32'd255);
        send_word(8'h3C, 1'b1);
        check("wrap_wc_256", wc_m, 32'd0);
        check("wrap_out_3c", out_m, 32'h3C);
        send_word(8'hC3, 1'b1);
        check("wrap_wc_257", wc_m, 32'd1);
        check("wrap_out_c3", out_m, 32'hC3);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("final_valid", valid_m, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/serial_byte_loader.md
Name: serial_byte_loader

Overview:
Upstream stage of the ones-count datapath. Assembles a serial bit stream into a parallel word with a valid/ready handshake on the serial side. Presents the word on out_reg with out_valid and holds it stable until the consumer acknowledges. The ones-count block reads out_reg directly as its 8-bit input register.

Parameters:
WIDTH, 8, bits per assembled word (2..16)
MSB_FIRST, 1, 1: first accepted bit lands in out_reg[WIDTH-1]; 0: first bit lands in out_reg[0]

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
ser_in  input  1  serial data bit
ser_valid  input  1  ser_in carries a valid bit this cycle
ser_ready  output  1  loader can accept a bit this cycle
flush  input  1  synchronous discard of a partially assembled word
out_reg  output  WIDTH  assembled word
out_valid  output  1  out_reg holds a complete, unacknowledged word
out_ack  input  1  consumer has taken out_reg
bit_count  output  clog2(WIDTH+1)  bits accepted into the current word
word_count  output  8  completed words since reset; wraps 255->0

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. No asynchronous paths.
- Reset (rst_n=0 at an edge):
  - state=IDLE; shift register=0; out_reg=0; out_valid=0; bit_count=0; word_count=0; ser_ready=0.
  - ser_ready becomes 1 on the first edge with rst_n=1.
  - Reset mid-word or mid-HOLD discards everything.
- Registers: all outputs are registered. ser_ready=1 in IDLE and SHIFT, 0 in HOLD.
- Bit acceptance: a bit is accepted when ser_valid=1 and ser_ready=1 at a rising edge, with no flush.
- States:
  - IDLE: bit_count=0. An accepted bit loads into the shift register, bit_count=1, next state SHIFT. If WIDTH reaches full here, the completion rule applies.
  - SHIFT: each accepted bit is shifted in and bit_count increments. On the edge accepting bit number WIDTH, the same edge does all of the following: out_reg <= completed word, out_valid <= 1, ser_ready <= 0, bit_count <= 0, word_count <= word_count+1 (mod 256), state <= HOLD. out_valid is therefore high in the cycle after the last bit's edge.
  - HOLD: out_reg is frozen. ser_valid is ignored and no bit is consumed. On an edge with out_ack=1: out_valid <= 0, ser_ready <= 1, state <= IDLE. The earliest next bit is accepted one cycle after the ack edge.
- Bit order:
  - MSB_FIRST=1: shift left, new bit enters at LSB; the first bit ends at WIDTH-1.
  - MSB_FIRST=0: shift right, new bit enters at MSB; the first bit ends at bit 0.
- out_reg changes only on word completion or reset. Partial words are never visible on out_reg.
- flush:
  - In IDLE or SHIFT: bit_count <= 0, shift register <= 0, state <= IDLE.
  - flush and a valid bit in the same cycle: flush wins and the bit is discarded (not counted).
  - In HOLD: ignored; out_reg, out_valid and word_count are unaffected.
- out_ack while out_valid=0 is ignored.
- out_ack held high continuously: each word stays valid exactly one cycle.
- ser_valid deasserted mid-word: state and bit_count hold indefinitely, with no timeout.
- word_count wraps 255 -> 0 on the 256th completion, with no flag.

Test Plan:
- Reset then MSB_FIRST=1: stream 1,0,1,1,0,0,1,0 on consecutive cycles, out_ack=0 -> out_valid rises the cycle after the 8th bit; out_reg=8'hB2, word_count=1, ser_ready=0; out_reg holds while ser_valid toggles.
- MSB_FIRST=0 instance: same stream -> out_reg=8'h4D.
- Back-to-back with out_ack tied 1: words 8'hFF then 8'h01 -> each out_valid pulse lasts 1 cycle; one idle cycle of ser_ready=0 between words; out_reg sequence FF, 01; word_count=2.
- Flush after 5 bits (1,1,1,1,1), then 8 bits of 0 -> bit_count shows 5 then 0; completed word=8'h00 (no carry-over); flush asserted with a valid bit also discards that bit.
- Reset asserted during HOLD with out_reg=8'hB2 -> next cycle out_reg=0, out_valid=0, word_count=0; ser_ready=1 one edge after rst_n releases.
- Complete 256 words with out_ack=1 -> word_count reads 0 after the 256th word, 1 after the 257th; out_ack pulses while out_valid=0 have no effect.
